// File: rtl/pipeline_pkg.sv
// Shared opcodes, register constants and controller state encoding for the 4-stage pipeline.
package pipeline_pkg;

  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [2:0] R0 = 3'b000;

  typedef enum logic [2:0] {
    StRun,
    StMemWait,
    StFlush,
    StDrain,
    StHalted
  } ctl_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module pipe_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Hazard, redirect, memory-freeze and halt-drain sequencer for the decode/execute/mem/wb pipeline.
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH  = 2,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [2:0]       d_s_1,
  input  logic [2:0]       d_s_2,
  input  logic             x_valid,
  input  logic [2:0]       x_opcode,
  input  logic [2:0]       x_tgt,
  input  logic             branch,
  input  logic [15:0]      branch_tgt,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_stall,
  output logic             decode_stall,
  output logic             exec_stall,
  output logic             decode_bubble,
  output logic             flush_front,
  output logic             pc_load,
  output logic [15:0]      pc_load_val,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned FR_W   = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;
  localparam int unsigned DR_W   = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned BUSY_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [FR_W-1:0]   FLUSH_INIT = FR_W'(FLUSH_DEPTH - 1);
  localparam logic [DR_W-1:0]   DRAIN_INIT = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST  = BUSY_W'(MEM_TIMEOUT - 1);

  ctl_state_t      state_q, state_d;
  ctl_state_t      run_state;
  logic [FR_W-1:0] flush_rem_q, flush_rem_d;
  logic [DR_W-1:0] drain_rem_q, drain_rem_d;
  logic            mem_timeout_q;

  logic pc_stall_c, decode_stall_c, exec_stall_c, decode_bubble_c;
  logic flush_front_c, pc_load_c, halted_c;
  logic load_use;
  logic timeout_hit;
  logic [BUSY_W-1:0] busy_cnt;

  assign load_use = x_valid && (x_opcode == OP_LW) && (x_tgt != R0) && d_valid &&
                    ((d_s_1 == x_tgt) || (d_s_2 == x_tgt));

  always_comb begin
    state_d         = state_q;
    flush_rem_d     = flush_rem_q;
    drain_rem_d     = drain_rem_q;
    pc_stall_c      = 1'b0;
    decode_stall_c  = 1'b0;
    exec_stall_c    = 1'b0;
    decode_bubble_c = 1'b0;
    flush_front_c   = 1'b0;
    pc_load_c       = 1'b0;
    halted_c        = 1'b0;

    // Once memory frees up, the cycle is handled as the state the freeze interrupted.
    run_state = state_q;
    if ((state_q == StMemWait) && !mem_busy) begin
      run_state = (flush_rem_q != '0) ? StFlush : StRun;
    end

    if (run_state == StHalted) begin
      pc_stall_c     = 1'b1;
      decode_stall_c = 1'b1;
      exec_stall_c   = 1'b1;
      halted_c       = 1'b1;
    end else if (halt_req && (run_state != StDrain)) begin
      pc_stall_c     = 1'b1;
      decode_stall_c = 1'b1;
      exec_stall_c   = mem_busy;
      flush_front_c  = 1'b1;
      flush_rem_d    = '0;
      if (DRAIN_CYCLES <= 1) begin
        state_d = StHalted;
      end else begin
        state_d     = StDrain;
        drain_rem_d = DRAIN_INIT;
      end
    end else begin
      unique case (run_state)
        StDrain: begin
          pc_stall_c     = 1'b1;
          decode_stall_c = 1'b1;
          exec_stall_c   = mem_busy;
          flush_front_c  = 1'b1;
          if (!mem_busy) begin
            if (drain_rem_q == DR_W'(1)) begin
              state_d = StHalted;
            end else begin
              drain_rem_d = drain_rem_q - DR_W'(1);
            end
          end
        end
        StMemWait: begin
          pc_stall_c     = 1'b1;
          decode_stall_c = 1'b1;
          exec_stall_c   = 1'b1;
        end
        StRun, StFlush: begin
          if (mem_busy) begin
            // Execute is frozen, so a pending branch or hazard re-presents after the wait.
            pc_stall_c     = 1'b1;
            decode_stall_c = 1'b1;
            exec_stall_c   = 1'b1;
            state_d        = StMemWait;
          end else if (run_state == StFlush) begin
            flush_front_c = 1'b1;
            flush_rem_d   = flush_rem_q - FR_W'(1);
            state_d       = (flush_rem_q == FR_W'(1)) ? StRun : StFlush;
          end else if (branch) begin
            pc_load_c     = 1'b1;
            flush_front_c = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_d     = StFlush;
              flush_rem_d = FLUSH_INIT;
            end else begin
              state_d = StRun;
            end
          end else if (load_use) begin
            pc_stall_c      = 1'b1;
            decode_stall_c  = 1'b1;
            decode_bubble_c = 1'b1;
            state_d         = StRun;
          end else begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      flush_rem_q <= '0;
      drain_rem_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      drain_rem_q <= drain_rem_d;
    end
  end

  // Controls are combinational, so force them low while reset is held.
  assign pc_stall      = rst_n & pc_stall_c;
  assign decode_stall  = rst_n & decode_stall_c;
  assign exec_stall    = rst_n & exec_stall_c;
  assign decode_bubble = rst_n & decode_bubble_c;
  assign flush_front   = rst_n & flush_front_c;
  assign pc_load       = rst_n & pc_load_c;
  assign halted        = rst_n & halted_c;
  assign pc_load_val   = (rst_n && pc_load_c) ? branch_tgt : 16'h0000;

  pipe_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall),
    .clr   (1'b0),
    .count (stall_count)
  );

  pipe_sat_counter #(
    .WIDTH (BUSY_W)
  ) u_busy_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_busy),
    .clr   (!mem_busy),
    .count (busy_cnt)
  );

  // Flag rises on the edge that completes the MEM_TIMEOUT-th consecutive busy cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_busy && (busy_cnt == BUSY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      mem_timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

endmodule
